angle_fetch: RTL

- Consumer end of the host angle handshake. Requests angles one at a time from the host angle source (hs_next_angle / hs_next_angle_ack / hs_has_next_angle / hs_angle).
- Buffers fetched angles in a small FIFO and presents them to the backprojection pipeline on a valid/ready interface.
- Reports completion once the host runs out of angles and the buffer has drained.

---
 rtl/angle_fetch_if.sv | 27 ++
 rtl/angle_fetch.sv | 109 ++++++++++
 2 files changed

// File: rtl/angle_fetch_if.sv
// Host angle handshake plus the outgoing angle stream, bundled for angle_fetch.
// master = angle_fetch side, slave = host source / backprojection pipeline side.
interface angle_fetch_if #(
  parameter int kAngleLength = 9
);
  // Host: a transfer happens on a clk edge where hs_next_angle && hs_next_angle_ack;
  // the consumer captures hs_angle and the host advances on that same edge.
  // Stream: angle_out moves on a clk edge where angle_valid && angle_ready; angle_out
  // holds steady while angle_valid && !angle_ready, and valid never depends on ready.
  logic                    hs_next_angle;
  logic                    hs_next_angle_ack;
  logic                    hs_has_next_angle;
  logic [kAngleLength-1:0] hs_angle;
  logic [kAngleLength-1:0] angle_out;
  logic                    angle_valid;
  logic                    angle_ready;

  modport master (
    output hs_next_angle, angle_out, angle_valid,
    input  hs_next_angle_ack, hs_has_next_angle, hs_angle, angle_ready
  );

  modport slave (
    input  hs_next_angle, angle_out, angle_valid,
    output hs_next_angle_ack, hs_has_next_angle, hs_angle, angle_ready
  );
endinterface

// File: rtl/angle_fetch.sv
// Pulls angles from the host one at a time into a small FIFO and streams them to the
// backprojection pipeline; reports done once the host is exhausted and the FIFO drains.
module angle_fetch #(
  parameter int kAngleLength = 9,
  parameter int kBufferDepth = 2,
  parameter int kCountLength = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  angle_fetch_if.master           bus,
  output logic [kCountLength-1:0] angle_count,
  output logic                    busy,
  output logic                    done,
  output logic [1:0]              state_dbg
);
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

  localparam int PtrW = (kBufferDepth > 1) ? $clog2(kBufferDepth) : 1;
  localparam int OccW = $clog2(kBufferDepth + 1);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(kBufferDepth - 1);
  localparam logic [OccW-1:0] FullOcc = OccW'(kBufferDepth);

  state_t                  state_q, state_d;
  logic [kAngleLength-1:0] mem_q [kBufferDepth];
  logic [kAngleLength-1:0] mem_d [kBufferDepth];
  logic [PtrW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [OccW-1:0]         occ_q, occ_d;
  logic [kCountLength-1:0] count_q, count_d;
  logic                    fifo_empty, fifo_full, push, pop, clear_run;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == LastPtr) ? '0 : p + PtrW'(1);
  endfunction

  assign fifo_empty = (occ_q == '0);
  assign fifo_full  = (occ_q == FullOcc);

  // A request raised on the cycle the host runs dry is never acked by a sane host,
  // but has_next gates the push so that cycle can never capture.
  assign bus.hs_next_angle = (state_q == S_FETCH) && !fifo_full;
  assign push = bus.hs_next_angle && bus.hs_next_angle_ack && bus.hs_has_next_angle;
  assign pop  = !fifo_empty && bus.angle_ready;

  assign bus.angle_valid = !fifo_empty;
  assign bus.angle_out   = fifo_empty ? '0 : mem_q[rd_ptr_q];
  assign angle_count     = count_q;
  assign busy            = (state_q == S_FETCH) || (state_q == S_DRAIN);
  assign done            = (state_q == S_DONE);
  assign state_dbg       = state_q;

  always_comb begin
    state_d   = state_q;
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    clear_run = 1'b0;

    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
      count_d  = count_q + kCountLength'(1);
    end
    if (push) begin
      mem_d[wr_ptr_q] = bus.hs_angle;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    occ_d = occ_q + OccW'(push) - OccW'(pop);

    case (state_q)
      S_IDLE: if (start) begin
        state_d   = S_FETCH;
        clear_run = 1'b1;
      end
      S_FETCH: if (!bus.hs_has_next_angle) state_d = S_DRAIN;
      S_DRAIN: if (fifo_empty) state_d = S_DONE;
      S_DONE: if (start) begin
        state_d   = S_FETCH;
        clear_run = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    if (clear_run) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      count_q  <= '0;
      for (int i = 0; i < kBufferDepth; i++) mem_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end
endmodule
